bin_to_bcd_digits: RTL and testbench

BIN_TO_BCD_DIGITS -- requirements
Module: bin_to_bcd_digits

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_add3.sv | 11 +
 rtl/bin_to_bcd_digits.sv | 92 +++++++++
 tb/tb_bin_to_bcd_digits.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and state type for the binary-to-BCD digit converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam int          DIGIT_BITS = 4;
    localparam int          MAX_VALUE  = 9999;
    // Digit code the display stage renders as a dash.
    localparam logic [3:0]  DASH_CODE  = 4'hA;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 to any digit that is 5 or more.
module bcd_add3 #(
    parameter int W = 4
) (
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    assign q = (d >= W'(5)) ? d + W'(3) : d;

endmodule

// File: rtl/bin_to_bcd_digits.sv
// Sequential double-dabble binary-to-BCD converter, one shift step per clock.
// Overflow digit code: all 9s when BCD_SATURATE_EN is defined, dashes otherwise.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high
// SHIFT | one add-3/shift step per cycle, BIN_BITS steps
// DONE  | publish digits_out/overflow, pulse out_valid
module bin_to_bcd_digits #(
    parameter int BIN_BITS   = 14,
    parameter int DIGITS     = 4,
    parameter int DIGIT_BITS = bcd_pkg::DIGIT_BITS,
    parameter int MAX_VALUE  = bcd_pkg::MAX_VALUE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_BITS-1:0]   bin_in,
    output logic                  busy,
    output logic                  out_valid,
    output logic [DIGIT_BITS-1:0] digits_out [DIGITS],
    output logic                  overflow
);
    import bcd_pkg::*;

    localparam int BCD_W = DIGITS * DIGIT_BITS;
    localparam int SCR_W = BCD_W + BIN_BITS;
    localparam int CNT_W = $clog2(BIN_BITS + 1);

`ifdef BCD_SATURATE_EN
    localparam logic [DIGIT_BITS-1:0] OVF_DIGIT = DIGIT_BITS'(9);
`else
    localparam logic [DIGIT_BITS-1:0] OVF_DIGIT = DIGIT_BITS'(DASH_CODE);
`endif

    bcd_state_t       state;
    logic [SCR_W-1:0] scratch;
    logic [SCR_W-1:0] scratch_fix;
    logic [CNT_W-1:0] shift_cnt;
    logic             ovf_acc;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // BCD field sits above the binary field; correct every nibble before the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 #(.W(DIGIT_BITS)) u_add3 (
            .d(scratch[BIN_BITS + g*DIGIT_BITS +: DIGIT_BITS]),
            .q(scratch_fix[BIN_BITS + g*DIGIT_BITS +: DIGIT_BITS])
        );
    end
    assign scratch_fix[BIN_BITS-1:0] = scratch[BIN_BITS-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            scratch   <= '0;
            shift_cnt <= '0;
            ovf_acc   <= 1'b0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            for (int i = 0; i < DIGITS; i++) digits_out[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        scratch   <= {{BCD_W{1'b0}}, bin_in};
                        shift_cnt <= CNT_W'(BIN_BITS);
                        ovf_acc   <= (32'(bin_in) > MAX_VALUE);
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch   <= {scratch_fix[SCR_W-2:0], 1'b0};
                    shift_cnt <= shift_cnt - CNT_W'(1);
                    if (shift_cnt == CNT_W'(1)) state <= DONE;
                end
                DONE: begin
                    out_valid <= 1'b1;
                    overflow  <= ovf_acc;
                    for (int i = 0; i < DIGITS; i++)
                        digits_out[i] <= ovf_acc ? OVF_DIGIT
                                                 : scratch[SCR_W-1-i*DIGIT_BITS -: DIGIT_BITS];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_digits.sv
// Scoreboard bench for bin_to_bcd_digits: driver pushes decimal-model results, monitor checks on out_valid.
module tb_bin_to_bcd_digits;

    localparam int BIN_BITS   = 14;
    localparam int DIGITS     = 4;
    localparam int DIGIT_BITS = 4;
    localparam int MAX_VALUE  = 9999;
    localparam int LATENCY    = BIN_BITS + 1;
`ifdef BCD_SATURATE_EN
    localparam logic [15:0] OVF_DIGITS = 16'h9999;
`else
    localparam logic [15:0] OVF_DIGITS = 16'hAAAA;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  in_valid = 1'b0;
    logic [BIN_BITS-1:0]   bin_in = '0;
    logic                  in_ready;
    logic                  busy;
    logic                  out_valid;
    logic                  overflow;
    logic [DIGIT_BITS-1:0] digits_out [DIGITS];

    typedef struct {
        logic [15:0] dig;
        logic        ovf;
        int          acc_cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [15:0] last_dig = '0;
    logic        last_ovf = 1'b0;

    bin_to_bcd_digits #(
        .BIN_BITS(BIN_BITS), .DIGITS(DIGITS), .DIGIT_BITS(DIGIT_BITS), .MAX_VALUE(MAX_VALUE)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bin_in(bin_in),
        .busy(busy), .out_valid(out_valid), .digits_out(digits_out), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Decimal reference: plain division, element 0 most significant.
    function automatic logic [15:0] ref_dig(input int v);
        logic [15:0] r = '0;
        int p = 1000;
        if (v > MAX_VALUE) return OVF_DIGITS;
        for (int i = 0; i < DIGITS; i++) begin
            r = {r[11:0], 4'((v / p) % 10)};
            p = p / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] dut_dig();
        logic [15:0] r = '0;
        for (int i = 0; i < DIGITS; i++) r = {r[11:0], digits_out[i]};
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            chk("in_ready_at_out_valid", in_ready, 1);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got digits %0h, expected no output", dut_dig());
            end else begin
                e = sb.pop_front();
                chk("digits", dut_dig(), e.dig);
                chk("overflow", overflow, e.ovf);
                chk("latency", cyc - e.acc_cyc, LATENCY);
                last_dig = e.dig;
                last_ovf = e.ovf;
            end
        end else begin
            chk("digits_stable", dut_dig(), last_dig);
            chk("overflow_stable", overflow, last_ovf);
        end
    end

    task automatic send(input int v, output int acc_cyc);
        exp_t e;
        int budget = 0;
        acc_cyc = -1;
        while (budget < 100) begin
            @(negedge clk);
            in_valid = 1'b1;
            bin_in   = BIN_BITS'(v);
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc_cyc   = cyc;
                e.dig     = ref_dig(v);
                e.ovf     = (v > MAX_VALUE);
                e.acc_cyc = cyc;
                sb.push_back(e);
                in_valid  = 1'b0;
                break;
            end
            budget++;
        end
        if (acc_cyc < 0) begin
            in_valid = 1'b0;
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: value %0d never accepted, expected accept within 100 cycles", v);
        end
    endtask

    task automatic drain();
        int b = 0;
        while (sb.size() > 0 && b < 4 * LATENCY) begin
            @(negedge clk);
            b++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_digits"}, dut_dig(), 0);
    endtask

    initial begin
        int c1, c2, c;
        #2;
        chk_reset_outputs("por");
        repeat (3) @(negedge clk);
        rst = 1'b1;

        send(1234, c);
        drain();

        send(0, c1);
        send(9999, c2);
        if (c1 >= 0 && c2 >= 0) chk("back_to_back_gap", c2 - c1, LATENCY + 1);
        drain();

        send(10000, c);
        send(16383, c);
        send(MAX_VALUE, c);
        drain();

        // Second request while busy must be dropped.
        send(1234, c);
        repeat (4) @(negedge clk);
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            in_valid = 1'b1;
            bin_in   = BIN_BITS'(42);
            chk("ignored_in_ready", in_ready, 0);
            chk("ignored_busy", busy, 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        drain();
        repeat (5) @(negedge clk);

        // Reset partway through a conversion.
        send(5678, c);
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b0;
        sb.delete();
        last_dig = '0;
        last_ovf = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2 * LATENCY) @(negedge clk);
        send(305, c);
        drain();

        for (int k = 0; k < 1000; k++) begin
            send(int'($urandom_range(16383)), c);
            repeat ($urandom_range(2)) @(negedge clk);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
